id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 249 ++++++++++++++++++++++++
 tb/tb_id_ex_reg.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg : decode -> execute pipeline register
//
// Carries the decoded instruction (PC, operands, register indices, immediate,
// opaque control bundle) from the decode stage to the execute stage with one
// clock of latency. Each rising edge is one of four operations, in priority
// order:
//   reset (active-low, synchronous) : clear everything, including bubble_cnt
//   flush                           : insert a bubble (all ex_ outputs zero)
//   stall                           : hold, but refresh held operands from WB
//   load                            : capture the decode-stage values
//
// bubble_cnt is a saturating 16-bit count of edges that put a bubble into
// execute: flush edges and load edges with id_valid=0.
//
// Build option:
//   WB_BYPASS_EN  when defined, a load edge also forwards the write-back
//                 data into the captured operands if wb_rd matches id_rs1 or
//                 id_rs2. When undefined the operands are captured unmodified.
//                 The stall-time refresh from write-back exists in both builds.
// -----------------------------------------------------------------------------
module id_ex_reg #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_RegWrite,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [15:0]       bubble_cnt
);

    // Operation selected for the current edge (reset is handled in the
    // register process because it overrides everything).
    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STALL = 2'd1,
        OP_FLUSH = 2'd2
    } op_e;

    // A write-back hits a source index only when it really writes and the
    // destination is not x0; x0 must never be forwarded.
    function automatic logic wb_hit(input logic       we,
                                    input logic [4:0] wrd,
                                    input logic [4:0] rs);
        logic hit;
        hit = 1'b0;
        if (we && (wrd != 5'd0) && (wrd == rs)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // Saturating 16-bit increment: sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = 16'hFFFF;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    // Stage registers and next-state values
    logic              valid_q,    valid_d;
    logic [XLEN-1:0]   pc_q,       pc_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [4:0]        rs1_q,      rs1_d;
    logic [4:0]        rs2_q,      rs2_d;
    logic [4:0]        rd_q,       rd_d;
    logic [XLEN-1:0]   imm_q,      imm_d;
    logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
    logic [15:0]       cnt_q,      cnt_d;

    op_e               op_s;
    logic [XLEN-1:0]   load_rs1_s;
    logic [XLEN-1:0]   load_rs2_s;

    // Decode the edge operation: flush beats stall, stall beats load.
    always_comb begin
        op_s = OP_LOAD;
        if (flush) begin
            op_s = OP_FLUSH;
        end else if (stall) begin
            op_s = OP_STALL;
        end else begin
            op_s = OP_LOAD;
        end
    end

    // Operand values captured on a load edge (optionally bypassed from WB).
    always_comb begin
        load_rs1_s = id_rs1_data;
        load_rs2_s = id_rs2_data;
`ifdef WB_BYPASS_EN
        if (wb_hit(wb_RegWrite, wb_rd, id_rs1)) begin
            load_rs1_s = wb_data;
        end else begin
            load_rs1_s = id_rs1_data;
        end
        if (wb_hit(wb_RegWrite, wb_rd, id_rs2)) begin
            load_rs2_s = wb_data;
        end else begin
            load_rs2_s = id_rs2_data;
        end
`else
        load_rs1_s = id_rs1_data;
        load_rs2_s = id_rs2_data;
`endif
    end

    // Next-state for the stage contents and the bubble counter.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        imm_d      = imm_q;
        ctrl_d     = ctrl_q;
        cnt_d      = cnt_q;

        case (op_s)
            OP_FLUSH: begin
                valid_d    = 1'b0;
                pc_d       = '0;
                rs1_data_d = '0;
                rs2_data_d = '0;
                rs1_d      = 5'd0;
                rs2_d      = 5'd0;
                rd_d       = 5'd0;
                imm_d      = '0;
                ctrl_d     = '0;
                cnt_d      = sat_inc16(cnt_q);
            end
            OP_STALL: begin
                // Held instruction may be waiting on a register that WB is
                // writing right now; pick the new value up so it is not stale
                // when the stall releases. Bubbles are left untouched.
                if (valid_q && wb_hit(wb_RegWrite, wb_rd, rs1_q)) begin
                    rs1_data_d = wb_data;
                end else begin
                    rs1_data_d = rs1_data_q;
                end
                if (valid_q && wb_hit(wb_RegWrite, wb_rd, rs2_q)) begin
                    rs2_data_d = wb_data;
                end else begin
                    rs2_data_d = rs2_data_q;
                end
            end
            OP_LOAD: begin
                valid_d    = id_valid;
                pc_d       = id_pc;
                rs1_data_d = load_rs1_s;
                rs2_data_d = load_rs2_s;
                rs1_d      = id_rs1;
                rs2_d      = id_rs2;
                rd_d       = id_rd;
                imm_d      = id_imm;
                // An invalid slot carries no control so it can never write.
                if (id_valid) begin
                    ctrl_d = id_ctrl;
                    cnt_d  = cnt_q;
                end else begin
                    ctrl_d = '0;
                    cnt_d  = sat_inc16(cnt_q);
                end
            end
            default: begin
                valid_d    = valid_q;
                pc_d       = pc_q;
                rs1_data_d = rs1_data_q;
                rs2_data_d = rs2_data_q;
                rs1_d      = rs1_q;
                rs2_d      = rs2_q;
                rd_d       = rd_q;
                imm_d      = imm_q;
                ctrl_d     = ctrl_q;
                cnt_d      = cnt_q;
            end
        endcase
    end

    // Stage register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            imm_q      <= '0;
            ctrl_q     <= '0;
            cnt_q      <= 16'd0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            imm_q      <= imm_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_imm      = imm_q;
    assign ex_ctrl     = ctrl_q;
    assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg : directed, table-driven bench for id_ex_reg (XLEN=32, CTRL_W=8)
// Vectors are applied one per clock edge in order, so state carries from one
// row to the next. Expected values are hand-computed. Honors WB_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [7:0]  id_ctrl;
    logic        wb_RegWrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [7:0]  ex_ctrl;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_reg #(.XLEN(32), .CTRL_W(8)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stl, fl, vld;
        logic [31:0] pc, r1d, r2d;
        logic [4:0]  r1, r2, rd;
        logic [31:0] imm;
        logic [7:0]  ctrl;
        logic        wwe;
        logic [4:0]  wrd;
        logic [31:0] wdat;
    } in_t;

    typedef struct {
        logic        vld;
        logic [31:0] pc, r1d, r2d;
        logic [4:0]  r1, r2, rd;
        logic [31:0] imm;
        logic [7:0]  ctrl;
        logic [15:0] cnt;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    function automatic in_t mi(logic rst, logic stl, logic fl, logic vld,
                               logic [31:0] pc, logic [31:0] r1d, logic [31:0] r2d,
                               logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                               logic [31:0] imm, logic [7:0] ctrl,
                               logic wwe, logic [4:0] wrd, logic [31:0] wdat);
        in_t v;
        v.rst = rst; v.stl = stl; v.fl = fl; v.vld = vld;
        v.pc = pc; v.r1d = r1d; v.r2d = r2d;
        v.r1 = r1; v.r2 = r2; v.rd = rd; v.imm = imm; v.ctrl = ctrl;
        v.wwe = wwe; v.wrd = wrd; v.wdat = wdat;
        return v;
    endfunction

    function automatic out_t mo(logic vld, logic [31:0] pc, logic [31:0] r1d,
                                logic [31:0] r2d, logic [4:0] r1, logic [4:0] r2,
                                logic [4:0] rd, logic [31:0] imm, logic [7:0] ctrl,
                                logic [15:0] cnt);
        out_t v;
        v.vld = vld; v.pc = pc; v.r1d = r1d; v.r2d = r2d;
        v.r1 = r1; v.r2 = r2; v.rd = rd; v.imm = imm; v.ctrl = ctrl; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        reset = v.rst; stall = v.stl; flush = v.fl; id_valid = v.vld;
        id_pc = v.pc; id_rs1_data = v.r1d; id_rs2_data = v.r2d;
        id_rs1 = v.r1; id_rs2 = v.r2; id_rd = v.rd;
        id_imm = v.imm; id_ctrl = v.ctrl;
        wb_RegWrite = v.wwe; wb_rd = v.wrd; wb_data = v.wdat;
    endtask

    task automatic check_all(input int k, input out_t e);
        chk($sformatf("v%0d ex_valid", k),    {31'd0, ex_valid}, {31'd0, e.vld});
        chk($sformatf("v%0d ex_pc", k),       ex_pc, e.pc);
        chk($sformatf("v%0d ex_rs1_data", k), ex_rs1_data, e.r1d);
        chk($sformatf("v%0d ex_rs2_data", k), ex_rs2_data, e.r2d);
        chk($sformatf("v%0d ex_rs1", k),      {27'd0, ex_rs1}, {27'd0, e.r1});
        chk($sformatf("v%0d ex_rs2", k),      {27'd0, ex_rs2}, {27'd0, e.r2});
        chk($sformatf("v%0d ex_rd", k),       {27'd0, ex_rd}, {27'd0, e.rd});
        chk($sformatf("v%0d ex_imm", k),      ex_imm, e.imm);
        chk($sformatf("v%0d ex_ctrl", k),     {24'd0, ex_ctrl}, {24'd0, e.ctrl});
        chk($sformatf("v%0d bubble_cnt", k),  {16'd0, bubble_cnt}, {16'd0, e.cnt});
    endtask

    vec_t tv[$];
    logic [31:0] byp_exp;

    initial begin
`ifdef WB_BYPASS_EN
        byp_exp = 32'd9;
`else
        byp_exp = 32'd7;
`endif
        // 0-1: reset with a valid instruction present (second also with stall+flush)
        tv.push_back('{mi(1'b0,1'b0,1'b0,1'b1,32'h40,32'h1,32'h2,5'd1,5'd2,5'd3,32'h4,8'h01,1'b0,5'd0,32'h0),
                       mo(1'b0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,32'h0,8'h00,16'd0)});
        tv.push_back('{mi(1'b0,1'b1,1'b1,1'b1,32'h40,32'h1,32'h2,5'd1,5'd2,5'd3,32'h4,8'h01,1'b0,5'd0,32'h0),
                       mo(1'b0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,32'h0,8'h00,16'd0)});
        // 2: first load
        tv.push_back('{mi(1'b1,1'b0,1'b0,1'b1,32'h100,32'd2,32'h33,5'd2,5'd4,5'd1,32'h10,8'h01,1'b0,5'd0,32'h0),
                       mo(1'b1,32'h100,32'd2,32'h33,5'd2,5'd4,5'd1,32'h10,8'h01,16'd0)});
        // 3-5: stall while id_ values change (row 5 has a non-matching WB)
        tv.push_back('{mi(1'b1,1'b1,1'b0,1'b1,32'h200,32'd5,32'd6,5'd7,5'd8,5'd9,32'h20,8'h02,1'b0,5'd0,32'h0),
                       mo(1'b1,32'h100,32'd2,32'h33,5'd2,5'd4,5'd1,32'h10,8'h01,16'd0)});
        tv.push_back('{mi(1'b1,1'b1,1'b0,1'b0,32'h204,32'd5,32'd6,5'd7,5'd8,5'd9,32'h20,8'h02,1'b0,5'd0,32'h0),
                       mo(1'b1,32'h100,32'd2,32'h33,5'd2,5'd4,5'd1,32'h10,8'h01,16'd0)});
        tv.push_back('{mi(1'b1,1'b1,1'b0,1'b1,32'h208,32'd5,32'd6,5'd7,5'd8,5'd9,32'h20,8'h02,1'b1,5'd9,32'h55),
                       mo(1'b1,32'h100,32'd2,32'h33,5'd2,5'd4,5'd1,32'h10,8'h01,16'd0)});
        // 6: flush + stall together -> bubble, count 1
        tv.push_back('{mi(1'b1,1'b1,1'b1,1'b1,32'h20c,32'd5,32'd6,5'd7,5'd8,5'd9,32'h20,8'h02,1'b0,5'd0,32'h0),
                       mo(1'b0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,32'h0,8'h00,16'd1)});
        // 7: load with id_valid=0 -> ctrl forced 0, count 2
        tv.push_back('{mi(1'b1,1'b0,1'b0,1'b0,32'h300,32'd5,32'd6,5'd7,5'd8,5'd9,32'h30,8'hFF,1'b0,5'd0,32'h0),
                       mo(1'b0,32'h300,32'd5,32'd6,5'd7,5'd8,5'd9,32'h30,8'h00,16'd2)});
        // 8: load bypass candidate, wb_rd == id_rs1
        tv.push_back('{mi(1'b1,1'b0,1'b0,1'b1,32'h304,32'd7,32'hA,5'd3,5'd11,5'd2,32'h0,8'h01,1'b1,5'd3,32'd9),
                       mo(1'b1,32'h304,byp_exp,32'hA,5'd3,5'd11,5'd2,32'h0,8'h01,16'd2)});
        // 9: WB to x0 with id_rs1 = x0 -> never forwarded
        tv.push_back('{mi(1'b1,1'b0,1'b0,1'b1,32'h308,32'd7,32'hA,5'd0,5'd11,5'd2,32'h0,8'h01,1'b1,5'd0,32'd9),
                       mo(1'b1,32'h308,32'd7,32'hA,5'd0,5'd11,5'd2,32'h0,8'h01,16'd2)});
        // 10: load ex_rs1=0, ex_rs2=4
        tv.push_back('{mi(1'b1,1'b0,1'b0,1'b1,32'h400,32'h12,32'h11,5'd0,5'd4,5'd6,32'h44,8'h03,1'b0,5'd0,32'h0),
                       mo(1'b1,32'h400,32'h12,32'h11,5'd0,5'd4,5'd6,32'h44,8'h03,16'd2)});
        // 11: stall refresh of rs2 with 0xDEAD, rest held
        tv.push_back('{mi(1'b1,1'b1,1'b0,1'b1,32'h500,32'd1,32'd1,5'd1,5'd1,5'd1,32'd1,8'hFF,1'b1,5'd4,32'hDEAD),
                       mo(1'b1,32'h400,32'h12,32'hDEAD,5'd0,5'd4,5'd6,32'h44,8'h03,16'd2)});
        // 12: stall with WB to x0 while ex_rs1 = x0 -> no refresh
        tv.push_back('{mi(1'b1,1'b1,1'b0,1'b1,32'h500,32'd1,32'd1,5'd1,5'd1,5'd1,32'd1,8'hFF,1'b1,5'd0,32'hBEEF),
                       mo(1'b1,32'h400,32'h12,32'hDEAD,5'd0,5'd4,5'd6,32'h44,8'h03,16'd2)});
        // 13: reset mid-stall discards the held instruction
        tv.push_back('{mi(1'b0,1'b1,1'b0,1'b1,32'h500,32'd1,32'd1,5'd1,5'd1,5'd1,32'd1,8'hFF,1'b0,5'd0,32'h0),
                       mo(1'b0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,32'h0,8'h00,16'd0)});
        // 14: first edge after reset release is a normal load
        tv.push_back('{mi(1'b1,1'b0,1'b0,1'b1,32'h600,32'h21,32'h22,5'd1,5'd2,5'd3,32'h60,8'h05,1'b0,5'd0,32'h0),
                       mo(1'b1,32'h600,32'h21,32'h22,5'd1,5'd2,5'd3,32'h60,8'h05,16'd0)});
        // 15: flush alone
        tv.push_back('{mi(1'b1,1'b0,1'b1,1'b1,32'h604,32'h21,32'h22,5'd1,5'd2,5'd3,32'h60,8'h05,1'b0,5'd0,32'h0),
                       mo(1'b0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,32'h0,8'h00,16'd1)});
        // 16: invalid load with rs1=rs2=7
        tv.push_back('{mi(1'b1,1'b0,1'b0,1'b0,32'h700,32'h70,32'h71,5'd7,5'd7,5'd1,32'h70,8'h01,1'b0,5'd0,32'h0),
                       mo(1'b0,32'h700,32'h70,32'h71,5'd7,5'd7,5'd1,32'h70,8'h00,16'd2)});
        // 17: stall with matching WB but ex_valid=0 -> no refresh
        tv.push_back('{mi(1'b1,1'b1,1'b0,1'b1,32'h704,32'd1,32'd1,5'd1,5'd1,5'd1,32'd1,8'h01,1'b1,5'd7,32'h99),
                       mo(1'b0,32'h700,32'h70,32'h71,5'd7,5'd7,5'd1,32'h70,8'h00,16'd2)});
        // 18: valid load rs1=rs2=8
        tv.push_back('{mi(1'b1,1'b0,1'b0,1'b1,32'h800,32'd1,32'd2,5'd8,5'd8,5'd9,32'h80,8'h01,1'b0,5'd0,32'h0),
                       mo(1'b1,32'h800,32'd1,32'd2,5'd8,5'd8,5'd9,32'h80,8'h01,16'd2)});
        // 19: stall refresh hits both operands
        tv.push_back('{mi(1'b1,1'b1,1'b0,1'b1,32'h804,32'd3,32'd3,5'd3,5'd3,5'd3,32'd3,8'h03,1'b1,5'd8,32'h88),
                       mo(1'b1,32'h800,32'h88,32'h88,5'd8,5'd8,5'd9,32'h80,8'h01,16'd2)});

        for (int k = 0; k < tv.size(); k++) begin
            @(negedge clk);
            drive(tv[k].i);
            @(posedge clk);
            #1;
            check_all(k, tv[k].o);
        end

        // Saturation: reset, then 65 540 invalid loads.
        @(negedge clk);
        drive(mi(1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,32'h0,8'h00,1'b0,5'd0,32'h0));
        @(posedge clk);
        #1;
        chk("sat reset", {16'd0, bubble_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int n = 1; n <= 65540; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) chk("sat first", {16'd0, bubble_cnt}, 32'd1);
            if (n == 65534) chk("sat FFFE", {16'd0, bubble_cnt}, 32'h0000FFFE);
            if (n == 65535) chk("sat FFFF", {16'd0, bubble_cnt}, 32'h0000FFFF);
        end
        chk("sat held", {16'd0, bubble_cnt}, 32'h0000FFFF);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("sat flush", {16'd0, bubble_cnt}, 32'h0000FFFF);
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b1;
        @(posedge clk);
        #1;
        chk("sat stall", {16'd0, bubble_cnt}, 32'h0000FFFF);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("sat clear", {16'd0, bubble_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
